// File: rtl/lvds_rx_frame_align.sv
// Bit-slip word aligner for a 9-lane 6x LVDS deserializer (frame lane [53:48]).
// Optional ALIGN_STATS_EN adds saturating slip/mismatch statistics outputs.
module lvds_rx_frame_align #(
  parameter logic [5:0] FCLK_PATTERN  = 6'b111000,
  parameter int         SETTLE_CYCLES = 4,
  parameter int         LOCK_COUNT    = 16,
  parameter int         ERR_THRESH    = 4,
  parameter int         MAX_SLIPS     = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_pll_lock,
  input  logic [53:0] rx_word,
  output logic        rx_data_align,
  output logic [47:0] data_out,
  output logic        data_valid,
  output logic        locked,
`ifdef ALIGN_STATS_EN
  output logic [7:0]  slip_count,
  output logic [15:0] err_count,
`endif
  output logic        align_fail
);

  localparam int MW = $clog2(LOCK_COUNT + 1);
  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int EW = $clog2(ERR_THRESH + 1);
  localparam int TW = $clog2(MAX_SLIPS + 1);

  localparam logic [MW-1:0] LCK_N = MW'(LOCK_COUNT);
  localparam logic [SW-1:0] SET_N = SW'(SETTLE_CYCLES);
  localparam logic [EW-1:0] ERR_N = EW'(ERR_THRESH);
  localparam logic [TW-1:0] SLP_N = TW'(MAX_SLIPS);

  typedef enum logic [2:0] {
    WAIT_PLL, CHECK, SLIP, SETTLE, VERIFY, LOCKED
  } state_e;

  state_e state_q, state_d;
  logic [MW-1:0] match_cnt_q, match_cnt_d;
  logic [SW-1:0] settle_q, settle_d;
  logic [EW-1:0] err_run_q, err_run_d;
  logic [TW-1:0] slip_try_q, slip_try_d;
  logic          align_fail_q, align_fail_d;
  logic          rx_data_align_q, rx_data_align_d;
  logic [47:0]   data_out_q, data_out_d;
  logic          locked_q, locked_d;
  logic          match;

  assign match = (rx_word[53:48] == FCLK_PATTERN);

  always_comb begin
    state_d      = state_q;
    match_cnt_d  = match_cnt_q;
    settle_d     = settle_q;
    err_run_d    = err_run_q;
    slip_try_d   = slip_try_q;
    align_fail_d = align_fail_q;
    unique case (state_q)
      WAIT_PLL: if (rx_pll_lock) state_d = CHECK;
      CHECK: begin
        if (!match) begin
          state_d = SLIP;
        end else if (LOCK_COUNT <= 1) begin
          state_d = LOCKED;
        end else begin
          state_d     = VERIFY;
          match_cnt_d = MW'(1);
        end
      end
      SLIP: begin
        state_d  = SETTLE;
        settle_d = '0;
        if (slip_try_q >= SLP_N - TW'(1)) begin
          align_fail_d = 1'b1;
          slip_try_d   = '0;
        end else begin
          slip_try_d = slip_try_q + TW'(1);
        end
      end
      SETTLE: begin
        if (settle_q >= SET_N - SW'(1)) state_d = CHECK;
        else settle_d = settle_q + SW'(1);
      end
      VERIFY: begin
        if (!match) begin
          state_d     = SLIP;
          match_cnt_d = '0;
        end else if (match_cnt_q >= LCK_N - MW'(1)) begin
          state_d     = LOCKED;
          match_cnt_d = LCK_N;
        end else begin
          match_cnt_d = match_cnt_q + MW'(1);
        end
      end
      LOCKED: begin
        if (match) begin
          err_run_d = '0;
        end else if (err_run_q >= ERR_N - EW'(1)) begin
          state_d   = CHECK;
          err_run_d = '0;
        end else begin
          err_run_d = err_run_q + EW'(1);
        end
      end
      default: state_d = WAIT_PLL;
    endcase
    if (state_d == LOCKED && state_q != LOCKED) begin
      slip_try_d   = '0;
      err_run_d    = '0;
      align_fail_d = 1'b0;
    end
    // Losing the PLL abandons any alignment progress but keeps align_fail.
    if (!rx_pll_lock) begin
      state_d     = WAIT_PLL;
      match_cnt_d = '0;
      settle_d    = '0;
      err_run_d   = '0;
      slip_try_d  = '0;
    end
    rx_data_align_d = (state_d == SLIP);
    locked_d        = (state_d == LOCKED);
    data_out_d      = locked_d ? rx_word[47:0] : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= WAIT_PLL;
      match_cnt_q     <= '0;
      settle_q        <= '0;
      err_run_q       <= '0;
      slip_try_q      <= '0;
      align_fail_q    <= 1'b0;
      rx_data_align_q <= 1'b0;
      data_out_q      <= '0;
      locked_q        <= 1'b0;
    end else begin
      state_q         <= state_d;
      match_cnt_q     <= match_cnt_d;
      settle_q        <= settle_d;
      err_run_q       <= err_run_d;
      slip_try_q      <= slip_try_d;
      align_fail_q    <= align_fail_d;
      rx_data_align_q <= rx_data_align_d;
      data_out_q      <= data_out_d;
      locked_q        <= locked_d;
    end
  end

  assign rx_data_align = rx_data_align_q;
  assign data_out      = data_out_q;
  assign data_valid    = locked_q;
  assign locked        = locked_q;
  assign align_fail    = align_fail_q;

`ifdef ALIGN_STATS_EN
  logic [7:0]  slip_cnt_q, slip_cnt_d;
  logic [15:0] err_cnt_q, err_cnt_d;

  always_comb begin
    slip_cnt_d = slip_cnt_q;
    err_cnt_d  = err_cnt_q;
    if (state_q == SLIP && slip_cnt_q != '1)
      slip_cnt_d = slip_cnt_q + 8'd1;
    if (state_q == LOCKED && !match && err_cnt_q != '1)
      err_cnt_d = err_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      slip_cnt_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      slip_cnt_q <= slip_cnt_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign slip_count = slip_cnt_q;
  assign err_count  = err_cnt_q;
`endif

endmodule

// File: tb/tb_lvds_rx_frame_align.sv
// Directed bench for lvds_rx_frame_align; models the deserializer rotating
// the frame-lane word by one position for every bit-slip pulse.
module tb_lvds_rx_frame_align;

  localparam logic [5:0] FCLK = 6'b111000;

  logic        clk = 1'b0;
  logic        rst;
  logic        pll;
  logic        fsel;
  logic [5:0]  frc;
  int          off;
  logic [47:0] data;
  logic [53:0] rx_word;
  logic        rx_data_align;
  logic [47:0] data_out;
  logic        data_valid;
  logic        locked;
  logic        align_fail;
`ifdef ALIGN_STATS_EN
  logic [7:0]  slip_count;
  logic [15:0] err_count;
`endif

  int tests = 0;
  int fails = 0;
  int dbl   = 0;

  always #5 clk = ~clk;

  function automatic logic [5:0] rot6(input int o);
    logic [5:0] p;
    p = FCLK;
    for (int i = 0; i < o; i++) p = {p[4:0], p[5]};
    return p;
  endfunction

  assign rx_word = {(fsel ? frc : rot6(off)), data};

  lvds_rx_frame_align dut (
    .clk           (clk),
    .reset         (rst),
    .rx_pll_lock   (pll),
    .rx_word       (rx_word),
    .rx_data_align (rx_data_align),
    .data_out      (data_out),
    .data_valid    (data_valid),
    .locked        (locked),
`ifdef ALIGN_STATS_EN
    .slip_count    (slip_count),
    .err_count     (err_count),
`endif
    .align_fail    (align_fail)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock; the modelled deserializer slips on the pulse it saw.
  task automatic step;
    logic s;
    s = rx_data_align;
    @(posedge clk);
    #1;
    if (s) off = (off == 0) ? 5 : off - 1;
    if (s && rx_data_align) dbl++;
  endtask

  task automatic wait_locked(input int max);
    for (int i = 0; i < max && !locked; i++) step;
  endtask

  task automatic wait_pulse(input int max);
    for (int i = 0; i < max && !rx_data_align; i++) step;
  endtask

  int          n;
  int          last;
  int          gap;
  logic [47:0] prev;

  initial begin
    rst = 1'b1; pll = 1'b1; fsel = 1'b0; frc = '0; off = 0; data = '0;
    step; step;
    chk("rst_align", rx_data_align, 0);
    chk("rst_data", data_out, 0);
    chk("rst_valid", data_valid, 0);
    chk("rst_locked", locked, 0);
    chk("rst_fail", align_fail, 0);

    // aligned from the start
    rst = 1'b0;
    n = 0;
    for (int i = 0; i < 16; i++) begin
      step;
      if (rx_data_align) n++;
    end
    chk("pre_lock", locked, 0);
    step;
    chk("lock_cycle16", locked, 1);
    chk("no_slips", n, 0);
    for (int i = 0; i < 4; i++) begin
      data = {16'($urandom), 32'($urandom)};
      prev = data;
      step;
      chk("data_lat1", data_out, prev);
    end
    chk("data_valid", data_valid, 1);

    // burst errors
    fsel = 1'b1; frc = 6'b000111;
    step; step; step;
    frc = FCLK;
    step;
    chk("burst3_hold", locked, 1);
    frc = 6'b000111;
    step; step; step;
    chk("burst_err3", locked, 1);
    step;
    chk("burst4_lock", locked, 0);
    chk("burst4_valid", data_valid, 0);
`ifdef ALIGN_STATS_EN
    chk("err_count", err_count, 7);
`endif
    step;
    chk("realign_slip", rx_data_align, 1);

    // never aligns
    frc = 6'b000000;
    n = 1; last = 0; gap = -1;
    for (int i = 1; i < 200 && n < 12; i++) begin
      step;
      if (rx_data_align) begin
        if (gap < 0) gap = i - last - 1;
        last = i;
        n++;
      end
    end
    chk("slip_count12", n, 12);
    chk("slip_gap", gap, 5);
    chk("fail_pre", align_fail, 0);
    step;
    chk("fail_set", align_fail, 1);
    chk("pulse_fall", rx_data_align, 0);

    // PLL loss inside the settle window
    wait_pulse(20);
    step;
    pll = 1'b0;
    step;
    chk("pll_set_align", rx_data_align, 0);
    chk("pll_set_locked", locked, 0);
    chk("pll_set_valid", data_valid, 0);
    chk("pll_set_data", data_out, 0);
    chk("pll_set_fail", align_fail, 1);
    pll = 1'b1; frc = FCLK;
    wait_locked(100);
    chk("fix_locked", locked, 1);
    chk("fix_fail_clr", align_fail, 0);

    // PLL loss while locked
    pll = 1'b0;
    step;
    chk("pll_lk_locked", locked, 0);
    chk("pll_lk_valid", data_valid, 0);
    chk("pll_lk_data", data_out, 0);
    chk("pll_lk_align", rx_data_align, 0);
    pll = 1'b1;
    wait_locked(100);
    chk("pll_relock", locked, 1);

    // start two slips off
    rst = 1'b1;
    step; step;
    fsel = 1'b0; off = 2; rst = 1'b0;
    n = 0; last = -1; gap = -1;
    for (int i = 0; i < 200 && !locked; i++) begin
      step;
      if (rx_data_align) begin
        if (last >= 0 && gap < 0) gap = i - last - 1;
        last = i;
        n++;
      end
    end
    chk("off2_pulses", n, 2);
    chk("off2_gap", gap, 5);
    chk("off2_locked", locked, 1);
`ifdef ALIGN_STATS_EN
    chk("off2_slipcnt", slip_count, 2);
`endif
    chk("pulse_width1", dbl, 0);

    // reset during a slip pulse
    fsel = 1'b1; frc = 6'b000000;
    wait_pulse(40);
    chk("slip_seen", rx_data_align, 1);
    rst = 1'b1;
    step;
    chk("rst_slip_align", rx_data_align, 0);
    chk("rst_slip_locked", locked, 0);
    chk("rst_slip_valid", data_valid, 0);
    chk("rst_slip_data", data_out, 0);
    chk("rst_slip_fail", align_fail, 0);
    rst = 1'b0;
    step;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
